line_mem_responder: RTL
=======================

Name: line_mem_responder

Overview:
- Responder end of the cache-line request/reqack/done handshake that ICache/DCache drive toward the arbiter.
- Serves full 512-bit lines from an internal line-addressed backing store after a programmable latency.
- Used as the memory endpoint for unit-level cache and arbiter benches, and as a stand-in for the Sysbus side in core bring-up.

Parameters:
- LINE_BITS, 512, line width in bits; the byte offset within a line is addr[5:0].
- DEPTH_LINES, 1024, number of lines in the store; must be a power of two; IDX_W = log2(DEPTH_LINES).
- BASE_ADDR, 64'h0, physical address of line 0; must be 64-byte aligned.
- LATENCY, 4, cycles from the reqack cycle to the done cycle; must be >= 1.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- request  input  1  requester holds this high until it sees reqack.
- wrenable  input  1  1 = line write, 0 = line read; sampled together with request.
- addr  input  64  byte address; bits [5:0] ignored.
- wdata  input  LINE_BITS  write line; sampled together with request.
- reqack  output  1  one-cycle pulse: request accepted.
- rdata  output  LINE_BITS  read line; valid in the done cycle and held until the next read's done.
- done  output  1  one-cycle pulse: transaction complete.
- err  output  1  pulses with done when the address is out of range.

Behaviour:
- Reset values: reqack=0, done=0, err=0, rdata=0, state=IDLE, latency counter=0.
- Reset does not clear the backing store.
- Reset mid-transaction aborts the transaction and returns to IDLE; a pending write is discarded.
- States: IDLE, WAIT, DONE.
- IDLE:
  - On an edge with request=1, capture addr, wrenable and wdata.
  - Compute off = addr - BASE_ADDR; the line is in range iff off[63:6] < DEPTH_LINES; idx = off[6 +: IDX_W].
  - Assert reqack for exactly the next cycle, load counter = LATENCY-1, go to WAIT.
- WAIT:
  - The reqack cycle is the first WAIT cycle.
  - Counter decrements each cycle; when the counter is 0, go to DONE.
- DONE (one cycle): done=1.
  - Read, in range: rdata = mem[idx].
  - Read, out of range: rdata = 0, err=1.
  - Write, in range: mem[idx] updated at the edge that enters DONE; rdata unchanged.
  - Write, out of range: write dropped, err=1.
  - Next state is IDLE.
- Latency: with request sampled at edge N, reqack is high in cycle N+1 and done is high in cycle N+LATENCY+1.
- LATENCY=1: reqack and done occupy consecutive cycles.
- Request inputs are ignored outside IDLE; changes to addr/wdata after acceptance have no effect.
- request still high in the IDLE cycle after done is a new transaction. Back-to-back spacing is done, then IDLE, then the next reqack; minimum 2 cycles between done pulses at LATENCY=1.
- Read-after-write to the same line returns the new data; there is no forwarding window because transactions are serialized.
- reqack and done are never high in the same cycle.
- done, reqack and err are all registered outputs.

Optional Feature:
- Macro: LINE_MEM_STATS_EN.
- Defined:
  - Adds output reads_served (32 bits) and output writes_served (32 bits).
  - Each increments at its done cycle, in-range transactions only.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then read of addr 64'h40 with store preloaded mem[1]=512'hA5 -> reqack in cycle N+1, done in cycle N+5 (LATENCY=4), rdata=512'hA5, err=0.
- Write wdata=512'hDEAD to addr 64'h1C7 (offset ignored, idx 7), then read 64'h1C0 -> write done produces no rdata change; read done returns 512'hDEAD.
- Read of addr BASE_ADDR + DEPTH_LINES*64 -> done with err=1, rdata=0; a write to the same address is dropped and mem is unchanged.
- request held high continuously across 3 reads with LATENCY=1 -> three reqack/done pairs; done pulses exactly 3 cycles apart (done, IDLE-accept, reqack, done); reqack and done never overlap.
- reset asserted in the second WAIT cycle of a write to 64'h80 -> no done; outputs return to 0; a later read of 64'h80 returns the pre-write contents.
- With LINE_MEM_STATS_EN defined: 2 reads, 1 write and 1 out-of-range read -> reads_served=2, writes_served=1.

Source files
------------

// File: rtl/line_mem_responder.sv
// ---------------------------------------------------------------------------
// line_mem_responder
//
// Responder end of the cache-line request/reqack/done handshake. Serves full
// lines from an internal line-addressed backing store after a fixed,
// parameterised latency. Used as the memory endpoint for cache and arbiter
// unit benches and as a Sysbus stand-in during core bring-up.
//
// Ports:
//   clk            core clock
//   reset          synchronous, active-high reset
//   request        requester holds high until it sees reqack
//   wrenable       1 = line write, 0 = line read (sampled with request)
//   addr[63:0]     byte address; bits [5:0] are ignored
//   wdata          write line (sampled with request)
//   reqack         one-cycle pulse: request accepted
//   rdata          read line; valid in the done cycle, held until next read
//   done           one-cycle pulse: transaction complete
//   err            pulses with done when the address is out of range
//
// Optional feature (macro LINE_MEM_STATS_EN):
//   reads_served[31:0]   in-range reads completed (wraps mod 2^32)
//   writes_served[31:0]  in-range writes completed (wraps mod 2^32)
// ---------------------------------------------------------------------------
module line_mem_responder #(
    parameter int          LINE_BITS   = 512,
    parameter int          DEPTH_LINES = 1024,
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter int          LATENCY     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 request,
    input  logic                 wrenable,
    input  logic [63:0]          addr,
    input  logic [LINE_BITS-1:0] wdata,
    output logic                 reqack,
    output logic [LINE_BITS-1:0] rdata,
    output logic                 done,
    output logic                 err
`ifdef LINE_MEM_STATS_EN
    ,
    output logic [31:0]          reads_served,
    output logic [31:0]          writes_served
`endif
);

    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_reqack;
    logic                 r_done;
    logic                 r_err;
    logic [LINE_BITS-1:0] r_rdata;

    // Captured request (datapath only, never needs a reset value).
    logic                 r_we;
    logic                 r_in_range;
    logic [IDX_W-1:0]     r_idx;
    logic [LINE_BITS-1:0] r_wdata;

    logic [LINE_BITS-1:0] r_mem [DEPTH_LINES];

    logic [63:0]          w_off;
    logic                 w_in_range;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_fire;

    // Offset from the window base; an address below BASE_ADDR wraps to a huge
    // offset and therefore lands out of range without a separate compare.
    assign w_off      = addr - BASE_ADDR;
    assign w_in_range = (w_off[63:6] < 58'(DEPTH_LINES));
    assign w_idx      = w_off[6 +: IDX_W];

    // Last WAIT cycle: the edge that ends it enters DONE and commits the access.
    assign w_fire = (r_state == S_WAIT) && (r_cnt == '0);

    // NOTE: the backing store and the captured request fields carry no reset;
    // clearing a memory array is not possible in one cycle in real RAM, and
    // the store must survive reset anyway.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && request) begin
            r_we       <= wrenable;
            r_in_range <= w_in_range;
            r_idx      <= w_idx;
            r_wdata    <= wdata;
        end
        // Reset on the committing edge aborts the write.
        if (!reset && w_fire && r_we && r_in_range) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_reqack <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_reqack <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (request) begin
                        r_reqack <= 1'b1;
                        r_cnt    <= CNT_W'(LATENCY - 1);
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= ~r_in_range;
                        if (!r_we) begin
                            r_rdata <= r_in_range ? r_mem[r_idx] : '0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LINE_MEM_STATS_EN
    logic [31:0] r_reads_served;
    logic [31:0] r_writes_served;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reads_served  <= '0;
            r_writes_served <= '0;
        end else if (w_fire && r_in_range) begin
            if (r_we) begin
                r_writes_served <= r_writes_served + 32'd1;
            end else begin
                r_reads_served  <= r_reads_served + 32'd1;
            end
        end
    end

    assign reads_served  = r_reads_served;
    assign writes_served = r_writes_served;
`endif

    assign reqack = r_reqack;
    assign done   = r_done;
    assign err    = r_err;
    assign rdata  = r_rdata;

endmodule
